// File: rtl/alt_vip_common_stream_input_lat.sv
// Avalon-ST video input stage: takes an upstream stream with ready latency 0..4 and
// re-presents it at ready latency 0 through a small skid FIFO, with optional framing check.
module alt_vip_common_stream_input_lat #(
  parameter int unsigned DATA_WIDTH    = 10,
  parameter int unsigned READY_LATENCY = 1,
  parameter int unsigned EXTRA_DEPTH   = 2,
  parameter bit          PACKET_CHECK  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  din_ready,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_sop,
  input  logic                  din_eop,
  input  logic                  int_ready,
  output logic                  int_valid,
  output logic [DATA_WIDTH-1:0] int_data,
  output logic                  int_sop,
  output logic                  int_eop,
  output logic                  err_overflow,
  output logic                  err_orphan,
  output logic                  err_no_eop
);

  localparam int unsigned FifoDepth = READY_LATENCY + 1 + EXTRA_DEPTH;
  localparam int unsigned PtrW      = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW      = $clog2(FifoDepth + 1);
  localparam int unsigned BeatW     = DATA_WIDTH + 2;

  localparam logic [CntW-1:0] DepthCnt    = CntW'(FifoDepth);
  // Leave room for every beat that may still be in flight after ready drops.
  localparam logic [CntW-1:0] ReadyThresh = CntW'(FifoDepth - READY_LATENCY - 1);
  localparam logic [PtrW-1:0] LastPtr     = PtrW'(FifoDepth - 1);

  logic [BeatW-1:0] mem_q [FifoDepth];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             in_packet_q, in_packet_d;
  logic             ready_q, overflow_q, orphan_q, no_eop_q;

  logic full, pop, push, orphan, no_eop, drop_full;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    full        = (count_q == DepthCnt);
    pop         = (count_q != '0) & int_ready;
    orphan      = 1'b0;
    no_eop      = 1'b0;
    in_packet_d = in_packet_q;
    if (PACKET_CHECK && din_valid) begin
      orphan = ~din_sop & ~in_packet_q;
      no_eop = din_sop & in_packet_q;
      if (!orphan) begin
        in_packet_d = (din_sop | in_packet_q) & ~din_eop;
      end
    end
    // A pop in the same cycle frees the slot the incoming beat needs.
    drop_full = din_valid & full & ~pop;
    push      = din_valid & ~orphan & ~drop_full;
    count_d   = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FifoDepth); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      in_packet_q <= 1'b0;
      ready_q     <= 1'b0;
      overflow_q  <= 1'b0;
      orphan_q    <= 1'b0;
      no_eop_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {din_sop, din_eop, din_data};
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q     <= count_d;
      in_packet_q <= in_packet_d;
      ready_q     <= (count_d <= ReadyThresh);
      if (drop_full) begin
        overflow_q <= 1'b1;
      end
      orphan_q <= orphan;
      no_eop_q <= no_eop;
    end
  end

  assign din_ready                    = ready_q;
  assign int_valid                    = (count_q != '0);
  assign {int_sop, int_eop, int_data} = mem_q[rd_ptr_q];
  assign err_overflow                 = overflow_q;
  assign err_orphan                   = orphan_q;
  assign err_no_eop                   = no_eop_q;

endmodule

// File: tb/tb_alt_vip_common_stream_input_lat.sv
// Bench for alt_vip_common_stream_input_lat: three instances (L=1/D=4, L=2/D=5, L=0/D=3)
// driven by a latency-respecting source and checked against a queue-based packet model.
module tb_alt_vip_common_stream_input_lat;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din_valid [3];
  logic       din_sop   [3];
  logic       din_eop   [3];
  logic [9:0] din_data  [3];
  logic       int_ready [3];
  logic       din_ready [3];
  logic       int_valid [3];
  logic [9:0] int_data  [3];
  logic       int_sop   [3];
  logic       int_eop   [3];
  logic       err_overflow [3];
  logic       err_orphan   [3];
  logic       err_no_eop   [3];

  int lat_of   [3] = '{1, 2, 0};
  int depth_of [3] = '{4, 5, 3};

  int errors = 0;
  int checks = 0;

  logic [11:0] src_q [$];  // {sop, eop, data} still to send
  logic [11:0] exp_q [$];  // beats the core should see, in order
  bit          hist  [5];  // hist[k] = din_ready k cycles back
  bit          in_pkt;
  bit          pend_orphan, pend_no_eop;
  int          max_occ, ticks, n_orphan, n_no_eop;

  always #5 clk = ~clk;

  alt_vip_common_stream_input_lat #(.DATA_WIDTH(10), .READY_LATENCY(1), .EXTRA_DEPTH(2),
    .PACKET_CHECK(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .din_ready(din_ready[0]), .din_valid(din_valid[0]),
    .din_data(din_data[0]), .din_sop(din_sop[0]), .din_eop(din_eop[0]),
    .int_ready(int_ready[0]), .int_valid(int_valid[0]), .int_data(int_data[0]),
    .int_sop(int_sop[0]), .int_eop(int_eop[0]), .err_overflow(err_overflow[0]),
    .err_orphan(err_orphan[0]), .err_no_eop(err_no_eop[0]));

  alt_vip_common_stream_input_lat #(.DATA_WIDTH(10), .READY_LATENCY(2), .EXTRA_DEPTH(2),
    .PACKET_CHECK(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din_ready(din_ready[1]), .din_valid(din_valid[1]),
    .din_data(din_data[1]), .din_sop(din_sop[1]), .din_eop(din_eop[1]),
    .int_ready(int_ready[1]), .int_valid(int_valid[1]), .int_data(int_data[1]),
    .int_sop(int_sop[1]), .int_eop(int_eop[1]), .err_overflow(err_overflow[1]),
    .err_orphan(err_orphan[1]), .err_no_eop(err_no_eop[1]));

  alt_vip_common_stream_input_lat #(.DATA_WIDTH(10), .READY_LATENCY(0), .EXTRA_DEPTH(2),
    .PACKET_CHECK(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .din_ready(din_ready[2]), .din_valid(din_valid[2]),
    .din_data(din_data[2]), .din_sop(din_sop[2]), .din_eop(din_eop[2]),
    .int_ready(int_ready[2]), .int_valid(int_valid[2]), .int_data(int_data[2]),
    .int_sop(int_sop[2]), .int_eop(int_eop[2]), .err_overflow(err_overflow[2]),
    .err_orphan(err_orphan[2]), .err_no_eop(err_no_eop[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_phase();
    src_q.delete();
    exp_q.delete();
    for (int j = 0; j < 5; j++) hist[j] = 1'b0;
    in_pkt      = 1'b0;
    pend_orphan = 1'b0;
    pend_no_eop = 1'b0;
    max_occ     = 0;
    ticks       = 0;
    n_orphan    = 0;
    n_no_eop    = 0;
  endtask

  // One clock of instance i: check outputs against the model, pop, then offer the next beat.
  task automatic tick(input int i, input bit rdy);
    logic [11:0] b;
    for (int j = 4; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = din_ready[i];
    chk("din_ready", din_ready[i], (exp_q.size() <= depth_of[i] - lat_of[i] - 1) ? 1 : 0);
    chk("int_valid", int_valid[i], (exp_q.size() != 0) ? 1 : 0);
    chk("err_orphan", err_orphan[i], pend_orphan);
    chk("err_no_eop", err_no_eop[i], pend_no_eop);
    chk("err_overflow", err_overflow[i], 0);
    if (err_orphan[i] === 1'b1) n_orphan++;
    if (err_no_eop[i] === 1'b1) n_no_eop++;
    int_ready[i] = rdy;
    if (int_valid[i] === 1'b1 && rdy && exp_q.size() != 0) begin
      b = exp_q.pop_front();
      chk("int_beat", {int_sop[i], int_eop[i], int_data[i]}, b);
    end
    pend_orphan = 1'b0;
    pend_no_eop = 1'b0;
    if (src_q.size() != 0 && hist[lat_of[i]]) begin
      b = src_q.pop_front();
      din_valid[i] = 1'b1;
      {din_sop[i], din_eop[i], din_data[i]} = b;
      if (!b[11] && !in_pkt) begin
        pend_orphan = 1'b1;
      end else begin
        if (b[11] && in_pkt) pend_no_eop = 1'b1;
        exp_q.push_back(b);
        in_pkt = (b[11] | in_pkt) & ~b[10];
      end
    end else begin
      din_valid[i] = 1'b0;
      {din_sop[i], din_eop[i], din_data[i]} = '0;
    end
    if (exp_q.size() > max_occ) max_occ = exp_q.size();
    @(posedge clk);
    #1;
    ticks++;
  endtask

  task automatic drain(input int i, input bit random_rdy, input int bound);
    while ((src_q.size() != 0 || exp_q.size() != 0 || pend_orphan || pend_no_eop)
           && ticks < bound) begin
      tick(i, random_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end
    chk("drained", src_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, k;
    for (int i = 0; i < 3; i++) begin
      din_valid[i] = 1'b0; din_sop[i] = 1'b0; din_eop[i] = 1'b0;
      din_data[i]  = '0;   int_ready[i] = 1'b0;
    end
    rst_n = 1'b0;

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_din_ready", din_ready[0], 0);
    chk("rst_int_valid", int_valid[0], 0);
    chk("rst_int_data", int_data[0], 0);
    chk("rst_int_sop", int_sop[0], 0);
    chk("rst_int_eop", int_eop[0], 0);
    chk("rst_overflow", err_overflow[0], 0);
    chk("rst_orphan", err_orphan[0], 0);
    chk("rst_no_eop", err_no_eop[0], 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_din_ready", din_ready[0], 1);
    chk("rel_int_valid", int_valid[0], 0);

    // Streaming, L=2, core always ready: no bubbles
    new_phase();
    for (int j = 0; j < 16; j++) src_q.push_back({j == 0, j == 15, 10'(j)});
    drain(1, 1'b0, 100);
    chk("stream_cycles", (ticks <= 16 + 2 + 1) ? 1 : 0, 1);

    // Backpressure, L=2, depth 5
    new_phase();
    for (int j = 0; j < 12; j++) src_q.push_back({j == 0, j == 11, 10'(100 + j)});
    repeat (15) tick(1, 1'b0);
    chk("bp_fill", max_occ, 5);
    drain(1, 1'b0, 200);

    // Wrap, L=0, depth 3, random core ready
    new_phase();
    k = 0;
    while (k < 200) begin
      len = $urandom_range(1, 8);
      for (int j = 0; j < len && k < 200; j++) begin
        src_q.push_back({j == 0, (j == len - 1) || (k == 199), 10'($urandom)});
        k++;
      end
    end
    drain(2, 1'b1, 3000);

    // Framing on L=1: orphan, open, no-eop, single-beat packet, orphan again
    new_phase();
    src_q.push_back({1'b0, 1'b0, 10'd7});
    src_q.push_back({1'b1, 1'b0, 10'd1});
    src_q.push_back({1'b1, 1'b0, 10'd2});
    src_q.push_back({1'b1, 1'b1, 10'd3});
    src_q.push_back({1'b0, 1'b0, 10'd9});
    drain(0, 1'b0, 100);
    chk("orphan_pulses", n_orphan, 2);
    chk("no_eop_pulses", n_no_eop, 2);

    // Overflow: push regardless of ready into a stalled depth-4 FIFO
    int_ready[0] = 1'b0;
    for (int j = 0; j < 6; j++) begin
      din_valid[0] = 1'b1; din_sop[0] = 1'b1; din_eop[0] = 1'b1; din_data[0] = 10'(20 + j);
      @(posedge clk);
      #1;
    end
    din_valid[0] = 1'b0;
    chk("ovf_set", err_overflow[0], 1);
    chk("ovf_head", {int_sop[0], int_eop[0], int_data[0]}, {2'b11, 10'd20});
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_sticky", err_overflow[0], 1);
    chk("ovf_valid", int_valid[0], 1);

    // Asynchronous reset with beats buffered
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_int_valid", int_valid[0], 0);
    chk("arst_overflow", err_overflow[0], 0);
    chk("arst_din_ready", din_ready[0], 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    int_ready[0] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk);
      #1;
      chk("post_rst_empty", int_valid[0], 0);
    end
    chk("post_rst_ready", din_ready[0], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
